int_ack_sequencer: RTL and testbench
====================================

# int_ack_sequencer

Cascade acknowledge sequencer for up to NCTRL interrupt controllers sharing one 8-bit vector bus. Merges controller requests into one CPU interrupt line, grants one controller per acknowledge by round-robin, drives that controller's inta for exactly three bytes (call opcode, low vector, vector page), and presents the assembled 16-bit vector to the CPU over a valid/ready handshake. It sits between the CPU core and the bank of interrupt controllers.

## Interface
- NCTRL, 4, number of cascaded controllers (2..8)
- CALL_OP, 8'hCD, expected first vector byte

- clock  in  1  CPU clock; all state on posedge
- reset  in  1  asynchronous, active-low
- ie  in  1  CPU interrupt enable
- ack_req  in  1  CPU requests a vector (level, sampled in IDLE)
- intr_in  in  NCTRL  intr from each controller
- bus_data  in  8  shared controller data bus
- inta_out  out  NCTRL  one-hot acknowledge, at most one bit high
- cpu_intr  out  1  interrupt request to CPU
- vec_valid  out  1  vector available
- vec_ready  in  1  CPU accepts vector
- vec_addr  out  16  {page, low}
- vec_src  out  3  index of granted controller
- vec_err  out  1  vector fault: bad opcode or spurious ack

## Operation
- States: IDLE, B0, B1, B2, PRESENT, GAP.
- cpu_intr = ie & |intr_in & (state==IDLE); combinational.
- IDLE: on ack_req & ie & |intr_in: grant = first requester at or after last_grant+1 (mod NCTRL, wrapping); register grant, set inta_out one-hot, go B0. On ack_req with ie=1 and no requester (spurious): vec_addr=0, vec_err=1, vec_src=0, go PRESENT, no inta. ack_req with ie=0 ignored.
- B0: sample bus_data into op; go B1. B1: sample low; go B2. B2: sample page; clear inta_out; go PRESENT.
- PRESENT: vec_valid=1; vec_addr={page,low}; vec_err=(op!=CALL_OP). Hold all outputs stable until vec_valid&vec_ready, then go GAP; last_grant<=grant.
- GAP: one idle cycle, lets the controller clear its active bit and intr before next arbitration; go IDLE.
- Bad opcode does not abort: all three inta cycles always run so the controller's three-step vectoring stays aligned.
- intr_in dropping during B0..B2 ignored; sequence completes.
- ie deassert mid-sequence ignored.

## Timing
- Reset (async, low): state=IDLE, inta_out=0, vec_valid=0, vec_addr=0, vec_src=0, vec_err=0, last_grant=NCTRL-1 (so first grant starts at 0). cpu_intr follows its equation (0 while intr_in=0).
- inta_out high exactly 3 cycles: rises at posedge T (IDLE->B0), falls at posedge T+3. Controllers update the bus on negedge, so bytes are sampled at posedges T+1, T+2, T+3.
- vec_valid rises at T+3; earliest release T+3 if vec_ready already high; next grant no earlier than T+5.
- Spurious path: vec_valid one cycle after ack_req sampled.
- Reset mid-sequence: inta_out drops immediately; controllers must be reset by the same event.

## Structure
- Package int_ack_pkg: state enum, CALL_OP default, NCTRL bounds.
- Sub-module rr_arbiter (request vector, last_grant -> one-hot grant, index); combinational.

## Test plan
- Single request: intr_in=4'b0010, bus bytes CD/08/40, ack_req -> inta_out=0010 for 3 cycles, vec_addr=16'h4008, vec_src=1, vec_err=0.
- Round-robin: intr_in=4'b1001 held, four back-to-back acks -> grants 0,3,0,3; none granted twice in a row.
- Bad opcode: byte0=8'hC3 -> inta still 3 cycles, vec_err=1, vec_addr holds sampled bytes.
- Backpressure: vec_ready low 5 cycles -> vec_valid, vec_addr stable, no new inta until 1 cycle after acceptance.
- Spurious: ie=1, intr_in=0, ack_req=1 -> vec_valid, vec_err=1, vec_addr=0, inta_out never asserted; ie=0 -> ignored.
- Reset asserted in B1 -> inta_out=0 asynchronously, state IDLE, last_grant reset; next ack grants controller 0.

Source files
------------

// File: rtl/int_ack_pkg.sv
// Shared definitions for the cascade interrupt acknowledge sequencer:
// sequencer state encoding, default call opcode and controller-count bounds.
package int_ack_pkg;

    localparam int unsigned NCTRL_MIN       = 2;
    localparam int unsigned NCTRL_MAX       = 8;
    localparam int unsigned NCTRL_DEFAULT   = 4;
    localparam int unsigned SRC_W           = 3;
    localparam logic [7:0]  CALL_OP_DEFAULT = 8'hCD;

    // Acknowledge sequence: three inta byte cycles, then vector presentation
    // and a one-cycle gap so the granted controller can retire its request.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_B0      = 3'd1,
        ST_B1      = 3'd2,
        ST_B2      = 3'd3,
        ST_PRESENT = 3'd4,
        ST_GAP     = 3'd5
    } state_e;

    // Width of a controller index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/int_ack_sequencer_rr_arbiter.sv
// Round-robin arbiter: picks the first requester strictly after the last
// granted index, wrapping modulo N. Purely combinational.
module rr_arbiter
    import int_ack_pkg::*;
#(
    parameter int unsigned N  = NCTRL_DEFAULT,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int            cand_s;
    logic [IW-1:0] cand_idx_s;
    logic          found_s;

    // Scan requesters starting one past the previous winner.
    always_comb begin
        gnt_o      = '0;
        idx_o      = last_i;
        any_o      = 1'b0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = 1; i <= int'(N); i++) begin
            cand_s     = (int'(last_i) + i) % int'(N);
            cand_idx_s = IW'(cand_s);
            if (!found_s && req_i[cand_idx_s]) begin
                found_s           = 1'b1;
                gnt_o             = '0;
                gnt_o[cand_idx_s] = 1'b1;
                idx_o             = cand_idx_s;
                any_o             = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/int_ack_sequencer.sv
// Cascade acknowledge sequencer: merges controller requests into one CPU
// interrupt, grants one controller per acknowledge, runs its three inta byte
// cycles and presents the assembled vector over a valid/ready handshake.
module int_ack_sequencer
    import int_ack_pkg::*;
#(
    parameter int unsigned NCTRL   = NCTRL_DEFAULT,
    parameter logic [7:0]  CALL_OP = CALL_OP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ie_i,
    input  logic             ack_req_i,
    input  logic [NCTRL-1:0] intr_in_i,
    input  logic [7:0]       bus_data_i,
    output logic [NCTRL-1:0] inta_out_o,
    output logic             cpu_intr_o,
    output logic             vec_valid_o,
    input  logic             vec_ready_i,
    output logic [15:0]      vec_addr_o,
    output logic [2:0]       vec_src_o,
    output logic             vec_err_o
);

    localparam int unsigned IW = idx_width(NCTRL);

    state_e           state_q;
    logic [NCTRL-1:0] inta_q;
    logic [IW-1:0]    last_grant_q;
    logic [IW-1:0]    grant_q;
    logic [7:0]       op_q;
    logic [7:0]       low_q;
    logic             vec_valid_q;
    logic [15:0]      vec_addr_q;
    logic [2:0]       vec_src_q;
    logic             vec_err_q;

    logic [NCTRL-1:0] arb_gnt_s;
    logic [IW-1:0]    arb_idx_s;
    logic             arb_any_s;

    rr_arbiter #(
        .N  (NCTRL),
        .IW (IW)
    ) u_arb (
        .req_i  (intr_in_i),
        .last_i (last_grant_q),
        .gnt_o  (arb_gnt_s),
        .idx_o  (arb_idx_s),
        .any_o  (arb_any_s)
    );

    // The CPU only sees a request while the sequencer can accept an acknowledge.
    assign cpu_intr_o = ie_i & (|intr_in_i) & (state_q == ST_IDLE);

    assign inta_out_o  = inta_q;
    assign vec_valid_o = vec_valid_q;
    assign vec_addr_o  = vec_addr_q;
    assign vec_src_o   = vec_src_q;
    assign vec_err_o   = vec_err_q;

    // Acknowledge sequencer with registered inta and vector outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            inta_q       <= '0;
            last_grant_q <= IW'(NCTRL - 1);
            grant_q      <= IW'(NCTRL - 1);
            op_q         <= 8'h00;
            low_q        <= 8'h00;
            vec_valid_q  <= 1'b0;
            vec_addr_q   <= 16'h0000;
            vec_src_q    <= 3'd0;
            vec_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ack_req_i && ie_i) begin
                        if (arb_any_s) begin
                            grant_q <= arb_idx_s;
                            inta_q  <= arb_gnt_s;
                            state_q <= ST_B0;
                        end else begin
                            // Spurious acknowledge: report a fault vector and
                            // leave the round-robin pointer where it was.
                            grant_q     <= last_grant_q;
                            vec_addr_q  <= 16'h0000;
                            vec_src_q   <= 3'd0;
                            vec_err_q   <= 1'b1;
                            vec_valid_q <= 1'b1;
                            state_q     <= ST_PRESENT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_B0: begin
                    op_q    <= bus_data_i;
                    state_q <= ST_B1;
                end
                ST_B1: begin
                    low_q   <= bus_data_i;
                    state_q <= ST_B2;
                end
                ST_B2: begin
                    // A bad opcode is only flagged; all three byte cycles
                    // always run so the controller stays in step.
                    inta_q      <= '0;
                    vec_addr_q  <= {bus_data_i, low_q};
                    vec_src_q   <= SRC_W'(grant_q);
                    vec_err_q   <= (op_q != CALL_OP);
                    vec_valid_q <= 1'b1;
                    state_q     <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (vec_ready_i) begin
                        vec_valid_q  <= 1'b0;
                        last_grant_q <= grant_q;
                        state_q      <= ST_GAP;
                    end else begin
                        state_q <= ST_PRESENT;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    inta_q      <= '0;
                    vec_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Directed bench for int_ack_sequencer: a bus model plays the controllers,
// a queue holds expected vectors pushed at each acknowledge.
module tb_int_ack_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ie;
    logic        ack_req;
    logic [3:0]  intr_in;
    logic [7:0]  bus_data;
    logic [3:0]  inta_out;
    logic        cpu_intr;
    logic        vec_valid;
    logic        vec_ready;
    logic [15:0] vec_addr;
    logic [2:0]  vec_src;
    logic        vec_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [2:0]  src;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;

    logic [7:0] tbl [4][3];
    int bus_cnt = 0;
    int run_len = 0;
    bit aborted = 1'b0;

    int_ack_sequencer #(.NCTRL(4), .CALL_OP(8'hCD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ie_i        (ie),
        .ack_req_i   (ack_req),
        .intr_in_i   (intr_in),
        .bus_data_i  (bus_data),
        .inta_out_o  (inta_out),
        .cpu_intr_o  (cpu_intr),
        .vec_valid_o (vec_valid),
        .vec_ready_i (vec_ready),
        .vec_addr_o  (vec_addr),
        .vec_src_o   (vec_src),
        .vec_err_o   (vec_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller model: the acknowledged controller puts its next byte on the
    // bus at each negedge while its inta is high.
    always @(negedge clk) begin
        if (inta_out != 4'b0000) begin
            int ci;
            ci = 0;
            for (int k = 0; k < 4; k++) begin
                if (inta_out[k]) ci = k;
            end
            bus_data = (bus_cnt < 3) ? tbl[ci][bus_cnt] : 8'hEE;
            bus_cnt++;
        end else begin
            bus_data = 8'hEE;
            bus_cnt  = 0;
        end
    end

    // inta pulse monitor: at most one bit high, every complete pulse 3 cycles.
    always @(negedge clk) begin
        chk("inta_onehot0", {31'd0, $onehot0(inta_out)}, 32'd1);
        if (inta_out != 4'b0000) begin
            run_len++;
        end else begin
            if (run_len != 0 && !aborted) chk("inta_len", run_len, 32'd3);
            run_len = 0;
            aborted = 1'b0;
        end
    end

    always @(negedge rst_n) aborted = 1'b1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic [15:0] a, input logic [2:0] s, input logic e);
        exp_t x;
        x.addr = a;
        x.src  = s;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // Raise ack_req for one cycle from IDLE and check the resulting inta.
    task automatic do_ack(input string tag, input logic [3:0] exp_inta);
        @(negedge clk);
        ack_req = 1'b1;
        @(negedge clk);
        ack_req = 1'b0;
        chk({tag, "_inta"}, inta_out, exp_inta);
    endtask

    // Wait (bounded) for vec_valid, then compare against the queue head.
    task automatic collect(input string tag, input int exp_lat);
        int n;
        exp_t x;
        n = 0;
        while (!vec_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            x = exp_q.pop_front();
            last_exp = x;
            chk({tag, "_addr"}, vec_addr, x.addr);
            chk({tag, "_src"}, vec_src, x.src);
            chk({tag, "_err"}, vec_err, x.err);
        end
    endtask

    // Accepted vector: GAP then IDLE.
    task automatic drain(input string tag);
        @(negedge clk);
        chk({tag, "_released"}, vec_valid, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ie = 1'b0; ack_req = 1'b0; intr_in = 4'b0000;
        vec_ready = 1'b1; bus_data = 8'hEE;
        for (int c = 0; c < 4; c++) begin
            tbl[c][0] = 8'hCD; tbl[c][1] = 8'h00; tbl[c][2] = 8'h00;
        end
        #12;
        chk("rst_inta", inta_out, 4'b0000);
        chk("rst_valid", vec_valid, 1'b0);
        chk("rst_addr", vec_addr, 16'h0000);
        chk("rst_src", vec_src, 3'd0);
        chk("rst_err", vec_err, 1'b0);
        chk("rst_cpu_intr", cpu_intr, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from controller 1.
        ie = 1'b1; intr_in = 4'b0010;
        tbl[1][0] = 8'hCD; tbl[1][1] = 8'h08; tbl[1][2] = 8'h40;
        @(negedge clk);
        chk("cpu_intr_on", cpu_intr, 1'b1);
        push_exp(16'h4008, 3'd1, 1'b0);
        do_ack("single", 4'b0010);
        chk("cpu_intr_busy", cpu_intr, 1'b0);
        collect("single", 3);
        drain("single");

        // Round robin from a fresh reset with controllers 0 and 3 requesting.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        intr_in = 4'b1001;
        tbl[0][0] = 8'hCD; tbl[0][1] = 8'h00; tbl[0][2] = 8'h10;
        tbl[3][0] = 8'hCD; tbl[3][1] = 8'h33; tbl[3][2] = 8'h30;
        push_exp(16'h1000, 3'd0, 1'b0); do_ack("rr0", 4'b0001); collect("rr0", 3); drain("rr0");
        push_exp(16'h3033, 3'd3, 1'b0); do_ack("rr1", 4'b1000); collect("rr1", 3); drain("rr1");
        push_exp(16'h1000, 3'd0, 1'b0); do_ack("rr2", 4'b0001); collect("rr2", 3); drain("rr2");
        push_exp(16'h3033, 3'd3, 1'b0); do_ack("rr3", 4'b1000); collect("rr3", 3); drain("rr3");

        // Bad opcode from controller 2: full sequence, bytes kept, error flagged.
        intr_in = 4'b0100;
        tbl[2][0] = 8'hC3; tbl[2][1] = 8'h55; tbl[2][2] = 8'hAA;
        push_exp(16'hAA55, 3'd2, 1'b1);
        do_ack("badop", 4'b0100);
        collect("badop", 3);
        drain("badop");

        // Backpressure: vector held, no new acknowledge while pending.
        intr_in = 4'b0001; vec_ready = 1'b0;
        tbl[0][0] = 8'hCD; tbl[0][1] = 8'h11; tbl[0][2] = 8'h22;
        push_exp(16'h2211, 3'd0, 1'b0);
        do_ack("bp", 4'b0001);
        collect("bp", 3);
        ack_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", vec_valid, 1'b1);
            chk("bp_addr_hold", vec_addr, last_exp.addr);
            chk("bp_no_inta", inta_out, 4'b0000);
        end
        ack_req = 1'b0; vec_ready = 1'b1;
        drain("bp");

        // Spurious acknowledge: no requester, fault vector one cycle later.
        intr_in = 4'b0000;
        push_exp(16'h0000, 3'd0, 1'b1);
        do_ack("spur", 4'b0000);
        collect("spur", 0);
        drain("spur");

        // Acknowledge with interrupts disabled is ignored.
        ie = 1'b0; intr_in = 4'b0010; ack_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ie0_inta", inta_out, 4'b0000);
            chk("ie0_valid", vec_valid, 1'b0);
            chk("ie0_cpu_intr", cpu_intr, 1'b0);
        end
        ack_req = 1'b0;

        // Reset while in B1: inta drops at once, arbitration restarts at 0.
        ie = 1'b1; intr_in = 4'b0100;
        do_ack("rstmid", 4'b0100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_inta", inta_out, 4'b0000);
        chk("rstmid_valid", vec_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        intr_in = 4'b0101;
        push_exp(16'h2211, 3'd0, 1'b0);
        do_ack("after_rst", 4'b0001);
        collect("after_rst", 3);
        drain("after_rst");
        chk("final_cpu_intr", cpu_intr, 1'b1);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
